// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI burst manager.
package axi_pkg;

    localparam int unsigned ID_W   = 2;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = DATA_W / 8;
    // One extra bit so a 256-beat burst never wraps before the last-beat compare.
    localparam int unsigned CNT_W  = LEN_W + 1;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_8B    = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5
    } state_e;

    // Captured command fields that drive the address channels.
    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } cmd_t;

    // Worst-case response ordering is plain unsigned magnitude.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_manager.sv
// Single-outstanding AXI4 manager: command/stream interface to INCR bursts of 64-bit beats.
module axi_burst_manager
    import axi_pkg::*;
#(
    parameter logic [2:0] AXSIZE  = SIZE_8B,
    parameter logic [1:0] AXBURST = BURST_INCR
) (
    input  logic              clk,
    input  logic              n_rst,
    // command interface
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ID_W-1:0]   cmd_id,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    // write stream
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    // read stream
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    input  logic              rd_ready,
    // completion
    output logic              done,
    output logic [1:0]        done_resp,
    output logic              done_err,
    // AR
    output logic [ID_W-1:0]   ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [LEN_W-1:0]  ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    // R
    input  logic [ID_W-1:0]   RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    // AW
    output logic [ID_W-1:0]   AWID,
    output logic [ADDR_W-1:0] AWADDR,
    output logic [LEN_W-1:0]  AWLEN,
    output logic [2:0]        AWSIZE,
    output logic [1:0]        AWBURST,
    output logic              AWVALID,
    input  logic              AWREADY,
    // W
    output logic [DATA_W-1:0] WDATA,
    output logic [STRB_W-1:0] WSTRB,
    output logic              WLAST,
    output logic              WVALID,
    input  logic              WREADY,
    // B
    input  logic [ID_W-1:0]   BID,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY
);

    state_e           state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       resp_q, resp_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic [1:0]       done_resp_q, done_resp_d;
    logic             done_err_q, done_err_d;

    logic             at_last;
    logic             r_hs;
    logic             w_hs;
    logic             r_beat_err;

    // Beat position and handshake decode shared by the FSM and datapath.
    always_comb begin
        at_last    = (cnt_q == CNT_W'(cmd_q.len));
        r_hs       = (state_q == ST_R) && RVALID && rd_ready;
        w_hs       = (state_q == ST_W) && wr_valid && WREADY;
        r_beat_err = (RID != cmd_q.id) || (RLAST != at_last);
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; reads end only on the RLAST handshake, writes on the WLAST handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) state_d = cmd_write ? ST_AW : ST_AR;
            ST_AR:   if (ARREADY) state_d = ST_R;
            ST_R:    if (r_hs && RLAST) state_d = ST_IDLE;
            ST_AW:   if (AWREADY) state_d = ST_W;
            ST_W:    if (w_hs && at_last) state_d = ST_B;
            ST_B:    if (BVALID) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Channel handshake outputs; stream signals pass straight through in their data state.
    always_comb begin
        cmd_ready = 1'b0;
        ARVALID   = 1'b0;
        AWVALID   = 1'b0;
        RREADY    = 1'b0;
        rd_valid  = 1'b0;
        rd_last   = 1'b0;
        WVALID    = 1'b0;
        wr_ready  = 1'b0;
        WLAST     = 1'b0;
        BREADY    = 1'b0;
        case (state_q)
            ST_IDLE: cmd_ready = 1'b1;
            ST_AR:   ARVALID   = 1'b1;
            ST_R: begin
                RREADY   = rd_ready;
                rd_valid = RVALID;
                rd_last  = RLAST;
            end
            ST_AW:   AWVALID   = 1'b1;
            ST_W: begin
                WVALID   = wr_valid;
                wr_ready = WREADY;
                WLAST    = at_last;
            end
            ST_B:    BREADY    = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
    end

    // Address-channel fields are static for the whole burst.
    assign ARID    = cmd_q.id;
    assign ARADDR  = cmd_q.addr;
    assign ARLEN   = cmd_q.len;
    assign ARSIZE  = AXSIZE;
    assign ARBURST = AXBURST;
    assign AWID    = cmd_q.id;
    assign AWADDR  = cmd_q.addr;
    assign AWLEN   = cmd_q.len;
    assign AWSIZE  = AXSIZE;
    assign AWBURST = AXBURST;
    assign WDATA   = wr_data;
    assign WSTRB   = '1;
    assign rd_data = RDATA;

    assign done      = done_q;
    assign done_resp = done_resp_q;
    assign done_err  = done_err_q;

    // Command capture, beat counter, response/error accumulation and completion report.
    always_comb begin
        cmd_d       = cmd_q;
        cnt_d       = cnt_q;
        resp_d      = resp_q;
        err_d       = err_q;
        done_d      = 1'b0;
        done_resp_d = done_resp_q;
        done_err_d  = done_err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d       = '{id: cmd_id, addr: cmd_addr, len: cmd_len};
                    cnt_d       = '0;
                    resp_d      = OKAY;
                    err_d       = 1'b0;
                    done_resp_d = OKAY;
                    done_err_d  = 1'b0;
                end
            end
            ST_R: begin
                if (r_hs) begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    resp_d = resp_max(resp_q, RRESP);
                    err_d  = err_q | r_beat_err;
                    if (RLAST) begin
                        done_d      = 1'b1;
                        done_resp_d = resp_max(resp_q, RRESP);
                        done_err_d  = err_q | r_beat_err;
                    end
                end
            end
            ST_W: begin
                if (w_hs) cnt_d = cnt_q + CNT_W'(1);
            end
            ST_B: begin
                if (BVALID) begin
                    resp_d      = BRESP;
                    err_d       = err_q | (BID != cmd_q.id);
                    done_d      = 1'b1;
                    done_resp_d = BRESP;
                    done_err_d  = err_q | (BID != cmd_q.id);
                end
            end
            default: done_d = 1'b0;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cmd_q       <= '0;
            cnt_q       <= '0;
            resp_q      <= OKAY;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            done_resp_q <= OKAY;
            done_err_q  <= 1'b0;
        end else begin
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            resp_q      <= resp_d;
            err_q       <= err_d;
            done_q      <= done_d;
            done_resp_q <= done_resp_d;
            done_err_q  <= done_err_d;
        end
    end

endmodule

// File: tb/tb_axi_burst_manager.sv
// Randomized bench for axi_burst_manager with a transaction-phase reference model.
module tb_axi_burst_manager;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [1:0]  cmd_id = '0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [63:0] wr_data = '0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [63:0] rd_data;
    logic        rd_valid, rd_last, rd_ready = 1'b0;
    logic        done, done_err;
    logic [1:0]  done_resp;
    logic [1:0]  ARID, AWID, BID = '0, RID = '0;
    logic [31:0] ARADDR, AWADDR;
    logic [7:0]  ARLEN, AWLEN, WSTRB;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST, RRESP = '0, BRESP = '0;
    logic        ARVALID, ARREADY = 1'b0, AWVALID, AWREADY = 1'b0;
    logic [63:0] RDATA = '0, WDATA;
    logic        RLAST = 1'b0, RVALID = 1'b0, RREADY;
    logic        WLAST, WVALID, WREADY = 1'b0;
    logic        BVALID = 1'b0, BREADY;

    axi_burst_manager dut (
        .clk(clk), .n_rst(n_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
        .done(done), .done_resp(done_resp), .done_err(done_err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    always #5 clk = ~clk;

    // Transaction-level phase of the model: which channel the burst is waiting on.
    typedef enum logic [2:0] {P_IDLE, P_RADDR, P_RDATA, P_WADDR, P_WDATA, P_WRESP, P_DONE} ph_e;
    ph_e         ph = P_IDLE;
    logic [1:0]  exp_id = '0;
    logic [31:0] exp_addr = '0;
    logic [7:0]  exp_len = '0;
    int          exp_beat = 0;
    logic [1:0]  exp_resp = '0;
    logic        exp_err = 1'b0;

    int checks = 0, failures = 0;
    int r_seen = 0, w_seen = 0, wlast_seen = 0, done_seen = 0;
    int last_resp = -1, last_err = -1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic budget_fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=handshake t=%0t", nm, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison of every DUT output against the phase model.
    always @(negedge clk) begin
        chk("cmd_ready", 64'(cmd_ready), 64'(ph == P_IDLE || ph == P_DONE));
        chk("arvalid", 64'(ARVALID), 64'(ph == P_RADDR));
        if (ph == P_RADDR) begin
            chk("araddr", 64'(ARADDR), 64'(exp_addr));
            chk("arlen", 64'(ARLEN), 64'(exp_len));
            chk("arid", 64'(ARID), 64'(exp_id));
            chk("arsize", 64'(ARSIZE), 64'd3);
            chk("arburst", 64'(ARBURST), 64'd1);
        end
        chk("awvalid", 64'(AWVALID), 64'(ph == P_WADDR));
        if (ph == P_WADDR) begin
            chk("awaddr", 64'(AWADDR), 64'(exp_addr));
            chk("awlen", 64'(AWLEN), 64'(exp_len));
            chk("awid", 64'(AWID), 64'(exp_id));
            chk("awsize", 64'(AWSIZE), 64'd3);
            chk("awburst", 64'(AWBURST), 64'd1);
        end
        chk("rready", 64'(RREADY), 64'(ph == P_RDATA && rd_ready));
        chk("rd_valid", 64'(rd_valid), 64'(ph == P_RDATA && RVALID));
        chk("rd_last", 64'(rd_last), 64'(ph == P_RDATA && RLAST));
        if (ph == P_RDATA && RVALID) chk("rd_data", rd_data, RDATA);
        chk("wvalid", 64'(WVALID), 64'(ph == P_WDATA && wr_valid));
        chk("wr_ready", 64'(wr_ready), 64'(ph == P_WDATA && WREADY));
        if (ph == P_WDATA && wr_valid) begin
            chk("wdata", WDATA, wr_data);
            chk("wlast", 64'(WLAST), 64'(exp_beat == int'(exp_len)));
            chk("wstrb", 64'(WSTRB), 64'hFF);
        end
        chk("bready", 64'(BREADY), 64'(ph == P_WRESP));
        chk("done", 64'(done), 64'(ph == P_DONE));
        if (ph == P_DONE) begin
            chk("done_resp", 64'(done_resp), 64'(exp_resp));
            chk("done_err", 64'(done_err), 64'(exp_err));
        end
        if (done) begin
            done_seen++;
            last_resp = int'(done_resp);
            last_err  = int'(done_err);
        end
        if (rd_valid && rd_ready) r_seen++;
        if (WVALID && WREADY) begin
            w_seen++;
            if (WLAST) wlast_seen++;
        end
    end

    // Present a command; gap idle cycles first, then accept and start driving junk on cmd_*.
    task automatic start_cmd(input logic w, input logic [1:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input int gap);
        for (int i = 0; i < gap; i++) begin
            cmd_valid = 1'b0;
            tick();
            ph = P_IDLE;
        end
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_id    = id;
        cmd_addr  = addr;
        cmd_len   = len;
        tick();
        exp_id   = id;
        exp_addr = addr;
        exp_len  = len;
        exp_beat = 0;
        ph       = w ? P_WADDR : P_RADDR;
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_write = 1'($urandom_range(0, 1));
        cmd_id    = 2'($urandom_range(0, 3));
        cmd_addr  = $urandom;
        cmd_len   = 8'($urandom_range(0, 255));
    endtask

    // Read burst: subordinate returns nbeats beats with RLAST on the last one.
    task automatic do_read(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input int ar_wait, input int nbeats, input logic [1:0] rid,
                           input int rdy_mode, input int rresp_fix, input int gap);
        logic [1:0] resp;
        logic [1:0] rr;
        logic       hs;
        int         k;
        int         cyc;
        start_cmd(1'b0, id, addr, len, gap);
        for (int i = 0; i < ar_wait; i++) begin
            RVALID = 1'($urandom_range(0, 1));
            RLAST  = 1'($urandom_range(0, 1));
            tick();
        end
        RVALID  = 1'b0;
        RLAST   = 1'b0;
        ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;
        ph = P_RDATA;
        k = 0;
        cyc = 0;
        resp = 2'b00;
        while (k < nbeats && cyc < 4000) begin
            if ($urandom_range(0, 3) == 0) begin
                RVALID = 1'b0;
                RLAST  = 1'b0;
            end else begin
                RVALID = 1'b1;
                RDATA  = {$urandom, $urandom};
                RLAST  = (k == nbeats - 1);
                RID    = rid;
                RRESP  = (rresp_fix < 0) ? 2'($urandom_range(0, 3)) : 2'(rresp_fix);
            end
            case (rdy_mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = ~rd_ready;
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            hs = RVALID && rd_ready;
            rr = RRESP;
            tick();
            cyc++;
            if (hs) begin
                k++;
                if (rr > resp) resp = rr;
            end
        end
        if (k < nbeats) budget_fail("read_beats");
        RVALID    = 1'b0;
        RLAST     = 1'b0;
        cmd_valid = 1'b0;
        rd_ready  = 1'($urandom_range(0, 1));
        exp_resp  = resp;
        exp_err   = (nbeats != int'(len) + 1) || (rid != id);
        ph        = P_DONE;
    endtask

    // Write burst; rst_beat >= 0 pulls reset while that beat is being offered.
    task automatic do_write(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input int aw_wait, input int wstall, input logic [1:0] bresp,
                            input logic [1:0] bid, input int b_wait, input int rst_beat,
                            input int gap);
        logic hs;
        int   cyc;
        start_cmd(1'b1, id, addr, len, gap);
        wr_valid = 1'b1;
        wr_data  = {$urandom, $urandom};
        for (int i = 0; i < aw_wait; i++) tick();
        AWREADY = 1'b1;
        tick();
        AWREADY = 1'b0;
        ph = P_WDATA;
        cyc = 0;
        while (exp_beat <= int'(len) && cyc < 4000) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_data  = {$urandom, $urandom};
            WREADY   = (cyc < wstall) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (rst_beat >= 0 && exp_beat == rst_beat) begin
                wr_valid = 1'b1;
                WREADY   = 1'b1;
                #2;
                n_rst     = 1'b0;
                ph        = P_IDLE;
                cmd_valid = 1'b0;
                #1;
                chk("rst_wvalid", 64'(WVALID), 64'd0);
                chk("rst_wr_ready", 64'(wr_ready), 64'd0);
                chk("rst_awvalid", 64'(AWVALID), 64'd0);
                chk("rst_arvalid", 64'(ARVALID), 64'd0);
                chk("rst_bready", 64'(BREADY), 64'd0);
                chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
                chk("rst_done", 64'(done), 64'd0);
                wr_valid = 1'b0;
                WREADY   = 1'b0;
                repeat (2) @(negedge clk);
                #2;
                n_rst = 1'b1;
                tick();
                return;
            end
            hs = wr_valid && WREADY;
            tick();
            cyc++;
            if (hs) exp_beat++;
        end
        if (exp_beat <= int'(len)) budget_fail("write_beats");
        ph       = P_WRESP;
        wr_valid = 1'b0;
        WREADY   = 1'b0;
        for (int i = 0; i < b_wait; i++) tick();
        BVALID = 1'b1;
        BID    = bid;
        BRESP  = bresp;
        tick();
        BVALID    = 1'b0;
        cmd_valid = 1'b0;
        exp_resp  = bresp;
        exp_err   = (bid != id);
        ph        = P_DONE;
    endtask

    // Let the done cycle pass with no new command.
    task automatic settle();
        cmd_valid = 1'b0;
        tick();
        ph = P_IDLE;
    endtask

    initial begin
        int r0;
        int w0;
        int wl0;
        int d0;
        logic [7:0] ln;
        logic [1:0] idr;
        logic [1:0] rid;
        int nb;
        int sel;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_araddr", 64'(ARADDR), 64'd0);
        chk("reset_arlen", 64'(ARLEN), 64'd0);
        chk("reset_awid", 64'(AWID), 64'd0);
        chk("reset_done_resp", 64'(done_resp), 64'd0);
        chk("reset_done_err", 64'(done_err), 64'd0);
        #1;
        n_rst = 1'b1;
        tick();

        // Read len=3, id=2, delayed ARREADY, four OKAY beats.
        r0 = r_seen; last_resp = -1; last_err = -1;
        do_read(2'd2, 32'h100, 8'd3, 2, 4, 2'd2, 0, 0, 1);
        settle();
        chk("t1_done_resp", 64'(last_resp), 64'd0);
        chk("t1_done_err", 64'(last_err), 64'd0);
        chk("t1_beats", 64'(r_seen - r0), 64'd4);

        // Single-beat write with WREADY stalled, SLVERR response.
        w0 = w_seen; wl0 = wlast_seen; last_resp = -1; last_err = -1;
        do_write(2'd1, 32'h2000, 8'd0, 1, 3, 2'b10, 2'd1, 2, -1, 1);
        settle();
        chk("t2_done_resp", 64'(last_resp), 64'd2);
        chk("t2_done_err", 64'(last_err), 64'd0);
        chk("t2_wbeats", 64'(w_seen - w0), 64'd1);
        chk("t2_wlast", 64'(wlast_seen - wl0), 64'd1);

        // Eight-beat read with rd_ready toggling every cycle.
        r0 = r_seen; last_err = -1;
        do_read(2'd0, 32'h3000, 8'd7, 0, 8, 2'd0, 1, -1, 1);
        settle();
        chk("t3_beats", 64'(r_seen - r0), 64'd8);
        chk("t3_done_err", 64'(last_err), 64'd0);

        // Early RLAST on beat 2 with wrong RID.
        r0 = r_seen; last_resp = -1; last_err = -1;
        do_read(2'd0, 32'h4000, 8'd3, 1, 2, 2'd3, 0, 1, 1);
        settle();
        chk("t4_done_err", 64'(last_err), 64'd1);
        chk("t4_done_resp", 64'(last_resp), 64'd1);
        chk("t4_beats", 64'(r_seen - r0), 64'd2);

        // Maximum-length write: 256 beats, WLAST only on the last.
        w0 = w_seen; wl0 = wlast_seen; last_resp = -1;
        do_write(2'd3, 32'h5000, 8'hFF, 0, 0, 2'b00, 2'd3, 0, -1, 1);
        settle();
        chk("t5_wbeats", 64'(w_seen - w0), 64'd256);
        chk("t5_wlast", 64'(wlast_seen - wl0), 64'd1);
        chk("t5_done_resp", 64'(last_resp), 64'd0);

        // Reset during write beat 5; no completion, then a normal write.
        w0 = w_seen; d0 = done_seen;
        do_write(2'd2, 32'h6000, 8'd9, 0, 0, 2'b00, 2'd2, 0, 4, 1);
        chk("t6_wbeats", 64'(w_seen - w0), 64'd4);
        chk("t6_no_done", 64'(done_seen - d0), 64'd0);
        chk("t6_done_resp", 64'(done_resp), 64'd0);
        last_resp = -1; last_err = -1;
        do_write(2'd2, 32'h7000, 8'd2, 1, 0, 2'b11, 2'd0, 1, -1, 1);
        settle();
        chk("t7_done_resp", 64'(last_resp), 64'd3);
        chk("t7_done_err", 64'(last_err), 64'd1);

        // Randomized traffic, frequently back-to-back with the done cycle.
        for (int n = 0; n < 30; n++) begin
            ln  = 8'($urandom_range(0, 12));
            idr = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                nb  = int'(ln) + 1;
                sel = int'($urandom_range(0, 7));
                if (sel == 0) nb = nb + int'($urandom_range(1, 2));
                else if (sel == 1) nb = int'($urandom_range(1, nb));
                rid = ($urandom_range(0, 7) == 0) ? ~idr : idr;
                do_read(idr, $urandom, ln, int'($urandom_range(0, 3)), nb, rid, 2, -1,
                        int'($urandom_range(0, 2)));
            end else begin
                rid = ($urandom_range(0, 7) == 0) ? ~idr : idr;
                do_write(idr, $urandom, ln, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                         2'($urandom_range(0, 3)), rid, int'($urandom_range(0, 3)), -1,
                         int'($urandom_range(0, 2)));
            end
        end
        settle();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_burst_manager.md
Name: axi_burst_manager

Overview:
AXI4 manager (initiator) that drives the AR/R and AW/W/B channels from the manager side. It turns a simple command/stream interface into single-ID INCR bursts of 64-bit beats. Its AXI ports connect directly to the AXI port set of the DDR controller top, for traffic generation and system bring-up. It keeps one transaction outstanding at a time.

Parameters:
AXSIZE, 3'd3, ARSIZE/AWSIZE driven on every burst (8-byte beats)
AXBURST, 2'b01, ARBURST/AWBURST driven on every burst (INCR)

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when both valid and ready are high
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_id  in  2  AXI ID
cmd_addr  in  32  start address
cmd_len  in  8  beats minus 1
wr_data  in  64  write beat data
wr_valid  in  1  write beat available
wr_ready  out  1  write beat consumed
rd_data  out  64  read beat data
rd_valid  out  1  read beat valid
rd_last  out  1  final read beat
rd_ready  in  1  consumer accepts read beat
done  out  1  one-cycle completion pulse
done_resp  out  2  worst response seen in the burst
done_err  out  1  protocol mismatch flag (ID or last-beat position), valid with done
ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  2/32/8/3/2/1  read address channel
ARREADY  in  1
RID/RDATA/RRESP/RLAST/RVALID  in  2/64/2/1/1  read data channel
RREADY  out  1
AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out  2/32/8/3/2/1  write address channel
AWREADY  in  1
WDATA/WSTRB/WLAST/WVALID  out  64/8/1/1  write data channel
WREADY  in  1
BID/BRESP/BVALID  in  2/2/1  write response channel
BREADY  out  1

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst is asynchronous and active-low.
- States: IDLE, AR, R, AW, W, B.
- Reset: state is IDLE. All *VALID, RREADY, BREADY, wr_ready, rd_valid, rd_last, done and done_err are 0; done_resp is 2'b00. cmd_ready is 1 (it is decoded as state==IDLE). Address, ID and length registers are 0.
- IDLE: on cmd_valid&&cmd_ready, register id, addr and len, clear the beat counter, resp_acc and err_acc. Next state is AR if cmd_write=0, AW if cmd_write=1.
- Channel field drive: AR*/AW* fields come from the registers. ARSIZE/AWSIZE = AXSIZE, ARBURST/AWBURST = AXBURST. WSTRB = 8'hFF.
- AR: ARVALID=1, held with stable fields until ARREADY. When ARVALID&&ARREADY, next state is R (ARVALID is 0 from the next cycle).
- R:
  - RREADY = rd_ready. rd_valid = RVALID. rd_data = RDATA. rd_last = RLAST. All combinational, zero latency.
  - On each handshake, the beat counter increments.
  - resp_acc = max(resp_acc, RRESP) (unsigned compare).
  - err_acc is set if RID != id, or if RLAST=1 with counter != len, or if RLAST=0 with counter == len.
  - The burst ends only on the RLAST handshake. Extra beats past len are consumed and flagged. Next state is IDLE.
- AW: AWVALID=1 until AWREADY, then next state is W. AW completes before any W beat; this ordering is legal.
- W:
  - WVALID = wr_valid. wr_ready = WREADY. WDATA = wr_data.
  - WLAST = (counter == len), combinational.
  - Counter increments on each handshake. The WLAST handshake moves to B.
- B: BREADY=1. On BVALID, resp_acc = BRESP and err_acc |= (BID != id). Next state is IDLE.
- done: registered. It is 1 for exactly one cycle, the cycle after the final R or B handshake, coincident with returning to IDLE. done_resp and done_err are held until the next command is accepted.
- Throughput: a new command may be accepted in the same cycle done is high.
- Counter width and wrap: counter is 9 bits, so len=255 (256 beats) does not wrap before compare.
- Outside their states, WVALID, RREADY, BREADY, wr_ready and rd_valid are forced to 0.
- cmd_* inputs are ignored while state != IDLE.
- Reset mid-burst returns to IDLE immediately and drops all VALIDs asynchronously. No completion is reported.

Decomposition:
- Shared package axi_pkg holds:
  - state enum
  - resp constants: OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11
  - BURST_INCR 2'b01
  - SIZE_8B 3'd3
- Single module, no sub-module. The beat counter and response accumulator are inline.

Test Plan:
- Read len=3, id=2, addr=0x100, ARREADY delayed 2 cycles, 4 RVALID beats with RLAST on beat 4, RRESP OKAY -> ARLEN=3, ARADDR held 0x100, 4 rd_valid beats, done pulses 1 cycle later with done_resp=00, done_err=0.
- Write len=0, id=1, WREADY low for 3 cycles, BRESP=SLVERR -> WLAST=1 on the sole beat, BREADY asserted, done with done_resp=10.
- Read with rd_ready toggling every cycle on an 8-beat burst -> RREADY mirrors rd_ready, 8 accepted beats, no beat lost or duplicated.
- Read len=3 with RLAST on beat 2, and RID=3 vs id=0 -> completes after beat 2, done_err=1.
- Write len=255 -> 256 W beats, WLAST only on beat 256, AWLEN=8'hFF.
- Assert n_rst low during W beat 5 -> all VALIDs 0 immediately, cmd_ready=1, done never pulses; the next command proceeds normally.
